// File: rtl/tank_plant_pkg.sv
// Shared constants for the tank plant model: default parameters, the signed
// width used for the level update, and the start-counter saturation helper.
package tank_pkg;

  localparam int LEVEL_W_DEF    = 10;
  localparam int LEVEL_MAX_DEF  = 1000;
  localparam int LO_TH_DEF      = 300;
  localparam int HI_TH_DEF      = 700;
  localparam int PUMP_RATE_DEF  = 8;
  localparam int TICK_DIV_DEF   = 4;
  localparam int INIT_LEVEL_DEF = 0;

  // Three guard bits cover level + 2*PUMP_RATE - 15 without wrap, plus sign.
  localparam int RAW_GUARD = 3;

  localparam int                 START_W   = 8;
  localparam logic [START_W-1:0] START_SAT = 8'd255;

  function automatic int raw_width(input int level_w);
    return level_w + RAW_GUARD;
  endfunction

  function automatic logic [START_W-1:0] sat_inc(input logic [START_W-1:0] cnt);
    return (cnt == START_SAT) ? cnt : cnt + START_W'(1);
  endfunction

endpackage

// File: rtl/tank_plant_if.sv
// Signal bundle between the plant and whatever drives it (controller or bench).
// There is no handshake: every input is level-sampled on each rising Clk edge,
// and every output is a register that is valid in every cycle after reset.
interface tank_plant_if #(
  parameter int LEVEL_W = tank_pkg::LEVEL_W_DEF
);

  logic                         enable;
  logic                         b1;
  logic                         b2;
  logic [3:0]                   demand;
  logic                         clear_flags;
  logic                         w1;
  logic                         w0;
  logic [LEVEL_W-1:0]           level;
  logic                         overflow;
  logic                         dry;
  logic [tank_pkg::START_W-1:0] starts1;
  logic [tank_pkg::START_W-1:0] starts2;

  modport master (
    output enable, b1, b2, demand, clear_flags,
    input  w1, w0, level, overflow, dry, starts1, starts2
  );

  modport slave (
    input  enable, b1, b2, demand, clear_flags,
    output w1, w0, level, overflow, dry, starts1, starts2
  );

endinterface

// File: rtl/tank_plant_tick_gen.sv
// Simulation-tick prescaler: one-cycle tick every TICK_DIV enabled cycles.
module tick_gen #(
  parameter int TICK_DIV = tank_pkg::TICK_DIV_DEF
) (
  input  logic Clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int               CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == LAST);
  // Gate with enable so a paused counter parked on LAST cannot re-fire.
  assign tick   = enable & w_last;

  always_ff @(posedge Clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tank_plant.sv
// Water-tank plant: integrates level from pump commands and demand per tick,
// and produces float switches, sticky flags and per-pump start counts.
module tank_plant
  import tank_pkg::*;
#(
  parameter int LEVEL_W    = LEVEL_W_DEF,
  parameter int LEVEL_MAX  = LEVEL_MAX_DEF,
  parameter int LO_TH      = LO_TH_DEF,
  parameter int HI_TH      = HI_TH_DEF,
  parameter int PUMP_RATE  = PUMP_RATE_DEF,
  parameter int TICK_DIV   = TICK_DIV_DEF,
  parameter int INIT_LEVEL = INIT_LEVEL_DEF
) (
  input logic         Clk,
  input logic         reset,
  tank_plant_if.slave bus
);

  localparam int RAW_W = raw_width(LEVEL_W);

  localparam logic signed [RAW_W-1:0] FILL_ONE = RAW_W'(PUMP_RATE);
  localparam logic signed [RAW_W-1:0] FILL_TWO = RAW_W'(2 * PUMP_RATE);
  localparam logic signed [RAW_W-1:0] RAW_MAX  = RAW_W'(LEVEL_MAX);

  localparam logic [LEVEL_W-1:0] LVL_MAX  = LEVEL_W'(LEVEL_MAX);
  localparam logic [LEVEL_W-1:0] LVL_LO   = LEVEL_W'(LO_TH);
  localparam logic [LEVEL_W-1:0] LVL_HI   = LEVEL_W'(HI_TH);
  localparam logic [LEVEL_W-1:0] LVL_INIT = LEVEL_W'(INIT_LEVEL);

  logic                      w_tick;
  logic signed [RAW_W-1:0]   w_fill;
  logic signed [RAW_W-1:0]   w_raw;
  logic [LEVEL_W-1:0]        w_level_nxt;
  logic                      w_set_ovf;
  logic                      w_set_dry;

  logic [LEVEL_W-1:0]        r_level;
  logic                      r_w1;
  logic                      r_w0;
  logic                      r_overflow;
  logic                      r_dry;
  logic                      r_b1_prev;
  logic                      r_b2_prev;
  logic [START_W-1:0]        r_starts1;
  logic [START_W-1:0]        r_starts2;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .Clk    (Clk),
    .reset  (reset),
    .enable (bus.enable),
    .tick   (w_tick)
  );

  always_comb begin
    w_fill      = '0;
    w_level_nxt = r_level;
    w_set_ovf   = 1'b0;
    w_set_dry   = 1'b0;
    unique case ({bus.b1, bus.b2})
      2'b11:        w_fill = FILL_TWO;
      2'b01, 2'b10: w_fill = FILL_ONE;
      default:      w_fill = '0;
    endcase
    w_raw = $signed({{RAW_GUARD{1'b0}}, r_level}) + w_fill
          - $signed({{(RAW_W-4){1'b0}}, bus.demand});
    if (w_tick) begin
      if (w_raw > RAW_MAX) begin
        w_level_nxt = LVL_MAX;
        w_set_ovf   = 1'b1;
      end else if (w_raw[RAW_W-1]) begin
        w_level_nxt = '0;
        w_set_dry   = 1'b1;
      end else begin
        w_level_nxt = w_raw[LEVEL_W-1:0];
      end
    end
  end

  // Level, switches and flags; a set on the same edge as clear_flags wins.
  always_ff @(posedge Clk) begin
    if (reset) begin
      r_level    <= LVL_INIT;
      r_w1       <= 1'b0;
      r_w0       <= 1'b0;
      r_overflow <= 1'b0;
      r_dry      <= 1'b0;
    end else begin
      r_level <= w_level_nxt;
      r_w0    <= (r_level >= LVL_LO);
      r_w1    <= (r_level >= LVL_HI);
      if (w_set_ovf)            r_overflow <= 1'b1;
      else if (bus.clear_flags) r_overflow <= 1'b0;
      if (w_set_dry)            r_dry <= 1'b1;
      else if (bus.clear_flags) r_dry <= 1'b0;
    end
  end

  // Pump start counters run every cycle, regardless of tick or enable.
  always_ff @(posedge Clk) begin
    if (reset) begin
      r_b1_prev <= 1'b0;
      r_b2_prev <= 1'b0;
      r_starts1 <= '0;
      r_starts2 <= '0;
    end else begin
      r_b1_prev <= bus.b1;
      r_b2_prev <= bus.b2;
      if (bus.b1 && !r_b1_prev) r_starts1 <= sat_inc(r_starts1);
      if (bus.b2 && !r_b2_prev) r_starts2 <= sat_inc(r_starts2);
    end
  end

  assign bus.level    = r_level;
  assign bus.w1       = r_w1;
  assign bus.w0       = r_w0;
  assign bus.overflow = r_overflow;
  assign bus.dry      = r_dry;
  assign bus.starts1  = r_starts1;
  assign bus.starts2  = r_starts2;

endmodule

// File: tb/tb_tank_plant.sv
// Directed bench for tank_plant with default parameters, including a closed
// loop against a small Moore lead/lag pump-alternation controller.
module tb_tank_plant;
  import tank_pkg::*;

  logic Clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  tank_plant_if #(.LEVEL_W(LEVEL_W_DEF)) bus ();

  tank_plant u_dut (
    .Clk   (Clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock and reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask

  task automatic drive(input logic en, input logic p1, input logic p2, input logic [3:0] dem);
    bus.enable      = en;
    bus.b1          = p1;
    bus.b2          = p2;
    bus.demand      = dem;
    bus.clear_flags = 1'b0;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 1'b0, 4'd0);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    n_cmp++; if (bus.level !== 10'd0) begin n_bad++; $display("FAIL reset_level: got %0d expected 0", bus.level); end
    n_cmp++; if ({bus.w1, bus.w0} !== 2'b00) begin n_bad++; $display("FAIL reset_switches: got %b expected 00", {bus.w1, bus.w0}); end
    n_cmp++; if ({bus.overflow, bus.dry} !== 2'b00) begin n_bad++; $display("FAIL reset_flags: got %b expected 00", {bus.overflow, bus.dry}); end
    n_cmp++; if ({bus.starts1, bus.starts2} !== 16'h0000) begin n_bad++; $display("FAIL reset_starts: got %h expected 0000", {bus.starts1, bus.starts2}); end
    step(10);
    n_cmp++; if (bus.level !== 10'd0) begin n_bad++; $display("FAIL disabled_level: got %0d expected 0", bus.level); end
  endtask

  // Both pumps, no demand: +16 per tick, tick k lands on edge 4k after release.
  task automatic test_fill_and_overflow();
    drive(1'b1, 1'b1, 1'b1, 4'd0);
    apply_reset();
    step(3);
    n_cmp++; if (bus.level !== 10'd0) begin n_bad++; $display("FAIL first_tick_early: got %0d expected 0", bus.level); end
    step(1);
    n_cmp++; if (bus.level !== 10'd16) begin n_bad++; $display("FAIL first_tick: got %0d expected 16", bus.level); end
    step(71);
    n_cmp++; if (bus.level !== 10'd288 || bus.w0 !== 1'b0) begin n_bad++; $display("FAIL tick18: got level %0d w0 %b expected 288/0", bus.level, bus.w0); end
    step(1);
    n_cmp++; if (bus.level !== 10'd304 || bus.w0 !== 1'b0) begin n_bad++; $display("FAIL tick19: got level %0d w0 %b expected 304/0", bus.level, bus.w0); end
    step(1);
    n_cmp++; if (bus.w0 !== 1'b1 || bus.w1 !== 1'b0) begin n_bad++; $display("FAIL w0_rise: got w0 %b w1 %b expected 1/0", bus.w0, bus.w1); end
    step(98);
    n_cmp++; if (bus.level !== 10'd688 || bus.w1 !== 1'b0) begin n_bad++; $display("FAIL tick43: got level %0d w1 %b expected 688/0", bus.level, bus.w1); end
    step(1);
    n_cmp++; if (bus.level !== 10'd704 || bus.w1 !== 1'b0) begin n_bad++; $display("FAIL tick44: got level %0d w1 %b expected 704/0", bus.level, bus.w1); end
    step(1);
    n_cmp++; if (bus.w1 !== 1'b1) begin n_bad++; $display("FAIL w1_rise: got %b expected 1", bus.w1); end
    step(71);
    n_cmp++; if (bus.level !== 10'd992 || bus.overflow !== 1'b0) begin n_bad++; $display("FAIL tick62: got level %0d ovf %b expected 992/0", bus.level, bus.overflow); end
    step(4);
    n_cmp++; if (bus.level !== 10'd1000 || bus.overflow !== 1'b1) begin n_bad++; $display("FAIL tick63_clamp: got level %0d ovf %b expected 1000/1", bus.level, bus.overflow); end
    bus.clear_flags = 1'b1;
    step(1);
    bus.clear_flags = 1'b0;
    n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL clear_ovf: got %b expected 0", bus.overflow); end
    step(2);
    bus.clear_flags = 1'b1;
    step(1);
    bus.clear_flags = 1'b0;
    n_cmp++; if (bus.overflow !== 1'b1 || bus.level !== 10'd1000) begin n_bad++; $display("FAIL set_wins: got ovf %b level %0d expected 1/1000", bus.overflow, bus.level); end
  endtask

  task automatic test_dry_and_balance();
    drive(1'b1, 1'b0, 1'b0, 4'd5);
    apply_reset();
    step(3);
    n_cmp++; if (bus.dry !== 1'b0) begin n_bad++; $display("FAIL dry_early: got %b expected 0", bus.dry); end
    step(1);
    n_cmp++; if (bus.dry !== 1'b1 || bus.level !== 10'd0) begin n_bad++; $display("FAIL dry_set: got dry %b level %0d expected 1/0", bus.dry, bus.level); end
    bus.b1     = 1'b1;
    bus.demand = 4'd0;
    step(8);
    n_cmp++; if (bus.level !== 10'd16) begin n_bad++; $display("FAIL one_pump_fill: got %0d expected 16", bus.level); end
    bus.demand = 4'd8;
    for (int t = 0; t < 3; t++) begin
      step(4);
      n_cmp++; if (bus.level !== 10'd16) begin n_bad++; $display("FAIL balance_t%0d: got %0d expected 16", t, bus.level); end
    end
    n_cmp++; if (bus.dry !== 1'b1) begin n_bad++; $display("FAIL dry_sticky: got %b expected 1", bus.dry); end
    bus.clear_flags = 1'b1;
    step(1);
    bus.clear_flags = 1'b0;
    n_cmp++; if (bus.dry !== 1'b0) begin n_bad++; $display("FAIL clear_dry: got %b expected 0", bus.dry); end
  endtask

  task automatic test_starts();
    drive(1'b0, 1'b0, 1'b0, 4'd0);
    apply_reset();
    bus.b1 = 1'b1; step(1); bus.b1 = 1'b0; step(1);
    bus.b2 = 1'b1; step(1); bus.b2 = 1'b0; step(1);
    bus.b1 = 1'b1; step(10); bus.b1 = 1'b0; step(1);
    bus.b2 = 1'b1; step(3); bus.b2 = 1'b0; step(1);
    bus.b1 = 1'b1; step(2); bus.b1 = 1'b0; step(1);
    n_cmp++; if (bus.starts1 !== 8'd3) begin n_bad++; $display("FAIL starts1_count: got %0d expected 3", bus.starts1); end
    n_cmp++; if (bus.starts2 !== 8'd2) begin n_bad++; $display("FAIL starts2_count: got %0d expected 2", bus.starts2); end
    for (int i = 0; i < 251; i++) begin
      bus.b1 = 1'b1; step(1); bus.b1 = 1'b0; step(1);
    end
    n_cmp++; if (bus.starts1 !== 8'd254) begin n_bad++; $display("FAIL starts1_254: got %0d expected 254", bus.starts1); end
    for (int i = 0; i < 49; i++) begin
      bus.b1 = 1'b1; step(1); bus.b1 = 1'b0; step(1);
    end
    n_cmp++; if (bus.starts1 !== 8'd255) begin n_bad++; $display("FAIL starts1_sat: got %0d expected 255", bus.starts1); end
    n_cmp++; if (bus.starts2 !== 8'd2) begin n_bad++; $display("FAIL starts2_hold: got %0d expected 2", bus.starts2); end
  endtask

  // Reach 500 (31 ticks of +16, one of +4), pause with the prescaler at 2.
  task automatic test_enable_hold_and_reset();
    drive(1'b1, 1'b1, 1'b1, 4'd0);
    apply_reset();
    step(124);
    bus.demand = 4'd12;
    step(4);
    bus.demand = 4'd0;
    n_cmp++; if (bus.level !== 10'd500) begin n_bad++; $display("FAIL reach_500: got %0d expected 500", bus.level); end
    step(2);
    bus.enable = 1'b0;
    step(20);
    n_cmp++; if (bus.level !== 10'd500) begin n_bad++; $display("FAIL hold_level: got %0d expected 500", bus.level); end
    bus.enable = 1'b1;
    step(1);
    n_cmp++; if (bus.level !== 10'd500) begin n_bad++; $display("FAIL hold_phase_pre: got %0d expected 500", bus.level); end
    step(1);
    n_cmp++; if (bus.level !== 10'd516) begin n_bad++; $display("FAIL hold_phase_tick: got %0d expected 516", bus.level); end
    step(1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    n_cmp++; if (bus.level !== 10'd0 || {bus.w1, bus.w0} !== 2'b00) begin n_bad++; $display("FAIL midrun_reset: got level %0d sw %b expected 0/00", bus.level, {bus.w1, bus.w0}); end
    n_cmp++; if ({bus.starts1, bus.starts2} !== 16'h0000 || {bus.overflow, bus.dry} !== 2'b00) begin n_bad++; $display("FAIL midrun_reset_cnt: got %h flags %b expected 0000/00", {bus.starts1, bus.starts2}, {bus.overflow, bus.dry}); end
    step(3);
    n_cmp++; if (bus.level !== 10'd0) begin n_bad++; $display("FAIL pending_tick: got %0d expected 0", bus.level); end
    step(1);
    n_cmp++; if (bus.level !== 10'd16) begin n_bad++; $display("FAIL post_reset_tick: got %0d expected 16", bus.level); end
  endtask

  // Lead pump runs below HI; lag joins below LO; both stop at HI and lead swaps.
  task automatic test_closed_loop();
    int   ctl_state;
    logic lead;
    int   lvl_min;
    int   lvl_max;
    logic settled;
    int   diff;
    drive(1'b1, 1'b0, 1'b0, 4'd10);
    apply_reset();
    ctl_state = 0;
    lead      = 1'b0;
    lvl_min   = LEVEL_MAX_DEF;
    lvl_max   = 0;
    settled   = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (bus.w1) settled = 1'b1;
      if (settled) begin
        if (int'(bus.level) < lvl_min) lvl_min = int'(bus.level);
        if (int'(bus.level) > lvl_max) lvl_max = int'(bus.level);
      end
      case (ctl_state)
        0: if (!bus.w1) ctl_state = 1;
        1: if (!bus.w0) ctl_state = 2;
        default: if (bus.w1) begin ctl_state = 0; lead = ~lead; end
      endcase
      bus.b1 = (ctl_state == 2) || (ctl_state == 1 && lead == 1'b0);
      bus.b2 = (ctl_state == 2) || (ctl_state == 1 && lead == 1'b1);
      step(1);
    end
    diff = int'(bus.starts1) - int'(bus.starts2);
    n_cmp++; if (settled !== 1'b1) begin n_bad++; $display("FAIL loop_reached_hi: got %b expected 1", settled); end
    n_cmp++; if (lvl_min < LO_TH_DEF - 20) begin n_bad++; $display("FAIL loop_min: got %0d expected >= %0d", lvl_min, LO_TH_DEF - 20); end
    n_cmp++; if (lvl_max > HI_TH_DEF + 20) begin n_bad++; $display("FAIL loop_max: got %0d expected <= %0d", lvl_max, HI_TH_DEF + 20); end
    n_cmp++; if ({bus.overflow, bus.dry} !== 2'b00) begin n_bad++; $display("FAIL loop_flags: got %b expected 00", {bus.overflow, bus.dry}); end
    n_cmp++; if (diff > 1 || diff < -1) begin n_bad++; $display("FAIL loop_alternation: got %0d/%0d expected diff <= 1", bus.starts1, bus.starts2); end
    n_cmp++; if (bus.starts1 < 8'd2 || bus.starts2 < 8'd2) begin n_bad++; $display("FAIL loop_cycles: got %0d/%0d expected >= 2 each", bus.starts1, bus.starts2); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 4'd0);
    test_reset();
    test_fill_and_overflow();
    test_dry_and_balance();
    test_starts();
    test_enable_hold_and_reset();
    test_closed_loop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tank_plant.md
# tank_plant

Synthesizable water-tank plant model that closes the loop around the Moore pump-alternation controller. It consumes the controller's pump commands `b1`/`b2`, integrates tank level against a consumer demand, and produces the two float-switch signals `w1` (high) and `w0` (low) that the controller reads. It also tracks flags and per-pump start counts, so closed-loop benches can check alternation and fill behaviour without hand-driven `w1`/`w0` stimulus.

## Interface
Parameters:
- `LEVEL_W`, 10: level register width.
- `LEVEL_MAX`, 1000: tank capacity (saturation ceiling).
- `LO_TH`, 300: `w0` asserts when level >= LO_TH.
- `HI_TH`, 700: `w1` asserts when level >= HI_TH.
- `PUMP_RATE`, 8: level added per tick per running pump.
- `TICK_DIV`, 4: Clk cycles per simulation tick (>= 1).
- `INIT_LEVEL`, 0: level loaded on reset.

Ports:
- `Clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: tick prescaler runs only while high.
- `b1` in 1: pump 1 running.
- `b2` in 1: pump 2 running.
- `demand` in 4: units drained per tick.
- `clear_flags` in 1: clears sticky flags.
- `w1` out 1: high float switch (registered).
- `w0` out 1: low float switch (registered).
- `level` out LEVEL_W: current tank level.
- `overflow` out 1: sticky; set when level clamped at LEVEL_MAX.
- `dry` out 1: sticky; set when demand exceeded available water.
- `starts1` out 8: rising edges seen on `b1`, saturating at 255.
- `starts2` out 8: rising edges seen on `b2`, saturating at 255.

## Operation
- Reset values: `level`=INIT_LEVEL, tick counter=0, `w1`=`w0`=0, `overflow`=`dry`=0, `starts1`=`starts2`=0, previous-`b` registers=0.
- Tick: counter counts 0..TICK_DIV-1 while `enable`=1 and holds while `enable`=0. The tick fires in the cycle where the counter equals TICK_DIV-1, then the counter wraps to 0.
- On tick, compute `raw = level + PUMP_RATE*(b1+b2) - demand` in signed LEVEL_W+3 bits, using `b1`, `b2` and `demand` sampled in the tick cycle.
  - raw > LEVEL_MAX: level = LEVEL_MAX, set `overflow`.
  - raw < 0: level = 0, set `dry`.
  - Otherwise: level = raw.
- Off-tick: level holds.
- Switches: `w0` <= (level >= LO_TH), `w1` <= (level >= HI_TH), registered every cycle from the current `level` register.
- Flags: `clear_flags` clears both flags. If a set condition occurs in the same cycle, set wins.
- Start counters: evaluated every cycle, independent of tick and `enable`. A rising edge is `b`=1 with previous `b`=0. The counter increments unless it is already 255. A held-high pump counts once.
- Reset mid-operation restores all reset values on the next edge and discards any pending tick.

## Timing
- Level changes at the Clk edge ending the tick cycle.
- `w0`/`w1` follow the level one cycle later: 1-cycle latency.
- Flags update on the same edge as the clamped level.
- `starts*` update on the edge that samples the rising `b`.
- After reset release with `enable`=1, the first tick occurs in cycle TICK_DIV-1 (0-based), and `level` first changes at that edge.

## Structure
- Package `tank_pkg`:
  - Default parameter constants.
  - `LEVEL_W`-derived signed width constant for `raw`.
  - Start-counter width (8) and saturation value.
- Sub-module `tick_gen`: prescaler with `Clk`, `reset`, `enable` inputs and a one-cycle `tick` output.
- Level datapath, switch registers, flags and edge counters stay in `tank_plant`.

## Test plan
All scenarios use defaults.
- Reset, `enable`=1, `b1`=`b2`=1, `demand`=0: `level` increments by 16 per tick and reaches 304 at tick 19. `w0`=1 one cycle later, `w1`=0. `w1` rises one cycle after tick 44 (level 704).
- Continue filling from 992 (tick 62): tick 63 clamps `level` to 1000 and sets `overflow`. `clear_flags` on a non-clamping cycle clears it. `clear_flags` asserted on a clamping tick leaves `overflow`=1.
- Reset, `b1`=`b2`=0, `demand`=5: `level` stays 0 and `dry`=1 after the first tick. With `b1`=1, `demand`=8, `level` stays constant at each tick.
- Pulse `b1` high three times and `b2` twice, with `b1` held high for 10 cycles once: `starts1`=3, `starts2`=2. 300 pulses on `b1` leave `starts1`=255.
- `enable`=0 for 20 cycles at `level`=500: `level` and the tick phase are held. Asserting `reset` mid-run gives `level`=0, `w1`=`w0`=0, counters 0 and flags 0 after one edge.
- Closed loop with the pump-alternation controller and `demand`=10: the level settles between LO_TH and HI_TH, no flags are set, and |`starts1` - `starts2`| <= 1.
